// File: rtl/axi_lite_to_mem_bridge_if.sv
// AXI-Lite channel bundle: 32-bit address, 32-bit data, 4-bit write strobe.
interface axi_lite_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_to_mem_bridge.sv
// AXI-Lite slave to single-port memory-style device bridge with address window,
// configurable read latency and round-robin read/write arbitration.
module axi_lite_to_mem_bridge #(
    parameter int unsigned READ_LATENCY   = 1,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [31:0] SIZE_BYTES     = 32'h0000_1000,
    parameter int unsigned DEV_ADDR_WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    axi_lite_if.slave                 s_axi_lite,
    output logic                      device_req_o,
    output logic                      device_we_o,
    output logic [DEV_ADDR_WIDTH-1:0] device_addr_o,
    output logic [3:0]                device_be_o,
    output logic [31:0]               device_wdata_o,
    input  logic [31:0]               device_rdata_i
);

    typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_RESP, RD_WAIT, RD_RESP} state_e;

    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    state_e                    state_q;
    logic                      aw_held_q, w_held_q, wr_prio_q;
    logic [31:0]               awaddr_q, wdata_q;
    logic [3:0]                wstrb_q;
    logic [2:0]                cnt_q;
    logic                      req_q, we_q;
    logic [DEV_ADDR_WIDTH-1:0] addr_q;
    logic [3:0]                be_q;
    logic [31:0]               dwdata_q;
    logic                      bvalid_q, rvalid_q;
    logic [1:0]                bresp_q, rresp_q;
    logic [31:0]               rdata_q;

    logic aw_rdy, w_rdy, ar_rdy, tie;
    logic aw_hs, w_hs, ar_hs;
    logic ar_in_win, aw_in_win;

    // Unsigned wrap makes addresses below BASE_ADDR fail the window test too.
    assign ar_in_win = (s_axi_lite.araddr - BASE_ADDR) < SIZE_BYTES;
    assign aw_in_win = (awaddr_q - BASE_ADDR) < SIZE_BYTES;

    // Readies stay combinational so a tie can suppress the loser in the same cycle.
    always_comb begin
        aw_rdy = 1'b0;
        w_rdy  = 1'b0;
        ar_rdy = 1'b0;
        tie    = 1'b0;
        if (!rst && state_q == IDLE) begin
            tie = s_axi_lite.arvalid && (s_axi_lite.awvalid || s_axi_lite.wvalid)
                  && !aw_held_q && !w_held_q;
            if (tie) begin
                ar_rdy = !wr_prio_q;
                aw_rdy = wr_prio_q;
                w_rdy  = wr_prio_q;
            end else begin
                aw_rdy = !aw_held_q;
                w_rdy  = !w_held_q;
                ar_rdy = !(aw_held_q || w_held_q);
            end
        end
    end

    assign aw_hs = s_axi_lite.awvalid && aw_rdy;
    assign w_hs  = s_axi_lite.wvalid && w_rdy;
    assign ar_hs = s_axi_lite.arvalid && ar_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            wr_prio_q <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            dwdata_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            rvalid_q  <= 1'b0;
            rresp_q   <= '0;
            rdata_q   <= '0;
        end else begin
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            dwdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (tie) wr_prio_q <= ~wr_prio_q;
                    if (aw_hs) begin
                        aw_held_q <= 1'b1;
                        awaddr_q  <= s_axi_lite.awaddr;
                    end
                    if (w_hs) begin
                        w_held_q <= 1'b1;
                        wdata_q  <= s_axi_lite.wdata;
                        wstrb_q  <= s_axi_lite.wstrb;
                    end
                    if (ar_hs) begin
                        if (ar_in_win) begin
                            req_q   <= 1'b1;
                            be_q    <= '1;
                            addr_q  <= DEV_ADDR_WIDTH'(s_axi_lite.araddr - BASE_ADDR);
                            cnt_q   <= '0;
                            state_q <= RD_WAIT;
                        end else begin
                            rdata_q  <= '0;
                            rresp_q  <= 2'b10;
                            rvalid_q <= 1'b1;
                            state_q  <= RD_RESP;
                        end
                    end else if (aw_held_q && w_held_q) begin
                        state_q <= WR_ISSUE;
                        if (aw_in_win) begin
                            req_q    <= 1'b1;
                            we_q     <= 1'b1;
                            addr_q   <= DEV_ADDR_WIDTH'(awaddr_q - BASE_ADDR);
                            be_q     <= wstrb_q;
                            dwdata_q <= wdata_q;
                        end
                    end
                end
                WR_ISSUE: begin
                    aw_held_q <= 1'b0;
                    w_held_q  <= 1'b0;
                    bvalid_q  <= 1'b1;
                    bresp_q   <= aw_in_win ? 2'b00 : 2'b10;
                    state_q   <= WR_RESP;
                end
                WR_RESP: begin
                    if (s_axi_lite.bready) begin
                        bvalid_q <= 1'b0;
                        bresp_q  <= 2'b00;
                        state_q  <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == LAT) begin
                        rdata_q  <= device_rdata_i;
                        rresp_q  <= 2'b00;
                        rvalid_q <= 1'b1;
                        state_q  <= RD_RESP;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                RD_RESP: begin
                    if (s_axi_lite.rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_axi_lite.awready = aw_rdy;
    assign s_axi_lite.wready  = w_rdy;
    assign s_axi_lite.arready = ar_rdy;
    assign s_axi_lite.bvalid  = bvalid_q;
    assign s_axi_lite.bresp   = bresp_q;
    assign s_axi_lite.rvalid  = rvalid_q;
    assign s_axi_lite.rresp   = rresp_q;
    assign s_axi_lite.rdata   = rdata_q;

    assign device_req_o   = req_q;
    assign device_we_o    = we_q;
    assign device_addr_o  = addr_q;
    assign device_be_o    = be_q;
    assign device_wdata_o = dwdata_q;

endmodule

// File: tb/tb_axi_lite_to_mem_bridge.sv
// Bench for axi_lite_to_mem_bridge: directed and random AXI-Lite traffic against a
// word-array reference model, with a behavioural device that answers READ_LATENCY cycles late.
module tb_axi_lite_to_mem_bridge;
    localparam int unsigned RL   = 3;
    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam logic [31:0] SIZE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dreq, dwe;
    logic [11:0] daddr;
    logic [3:0]  dbe;
    logic [31:0] dwdata;
    logic [31:0] drdata = '0;

    always #5 clk = ~clk;

    axi_lite_if bus();

    axi_lite_to_mem_bridge #(
        .READ_LATENCY  (RL),
        .BASE_ADDR     (BASE),
        .SIZE_BYTES    (SIZE),
        .DEV_ADDR_WIDTH(12)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_lite    (bus),
        .device_req_o  (dreq),
        .device_we_o   (dwe),
        .device_addr_o (daddr),
        .device_be_o   (dbe),
        .device_wdata_o(dwdata),
        .device_rdata_i(drdata)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] dev_mem [1024] = '{default: '0};
    logic [31:0] ref_mem [1024] = '{default: '0};

    int          req_cnt = 0;
    int          req_cyc = -100;
    int          idle_viol = 0;
    int          rd_due = -1;
    logic [31:0] rd_val = '0;
    logic        last_we = 1'b0;
    logic [11:0] last_addr = '0;
    logic [3:0]  last_be = '0;
    logic [31:0] last_wdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Device model: data appears only in the cycle READ_LATENCY after req, random otherwise.
    always @(negedge clk) begin
        if (dreq) begin
            req_cnt++;
            req_cyc    = cyc;
            last_we    = dwe;
            last_addr  = daddr;
            last_be    = dbe;
            last_wdata = dwdata;
            if (dwe) begin
                for (int b = 0; b < 4; b++)
                    if (dbe[b]) dev_mem[daddr[11:2]][8*b +: 8] = dwdata[8*b +: 8];
            end else begin
                rd_due = cyc + RL;
                rd_val = dev_mem[daddr[11:2]];
            end
        end else if ({dwe, daddr, dbe, dwdata} !== '0) begin
            idle_viol++;
        end
        drdata = (cyc == rd_due) ? rd_val : $urandom;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int order);
        bit          aw_done, w_done, hs_aw, hs_w, inwin;
        int          n, req0, hcyc, bcyc, k;
        logic [31:0] off;
        logic [1:0]  expb;
        aw_done = 0; w_done = 0; n = 0; hcyc = -100;
        off = a - BASE; inwin = off < SIZE; expb = inwin ? 2'b00 : 2'b10;
        req0 = req_cnt;
        @(posedge clk); #1;
        if (order != 1) begin bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = s; end
        if (order != 2) begin bus.awvalid = 1'b1; bus.awaddr = a; end
        while (!(aw_done && w_done) && n < 40) begin
            @(negedge clk);
            hs_aw = bus.awvalid && bus.awready;
            hs_w  = bus.wvalid && bus.wready;
            if (hs_aw || hs_w) hcyc = cyc;
            @(posedge clk); #1;
            n++;
            if (hs_aw) begin bus.awvalid = 1'b0; aw_done = 1; end
            if (hs_w)  begin bus.wvalid  = 1'b0; w_done  = 1; end
            if (n == 2 && order == 1) begin bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = s; end
            if (n == 2 && order == 2) begin bus.awvalid = 1'b1; bus.awaddr = a; end
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("wr_accept", aw_done && w_done, 1);
        n = 0;
        @(negedge clk);
        while (!bus.bvalid && n < 20) begin @(negedge clk); n++; end
        bcyc = cyc;
        check("bvalid_seen", bus.bvalid, 1);
        check("bresp", bus.bresp, expb);
        if (inwin) begin
            check("wr_req_cnt", req_cnt - req0, 1);
            check("wr_req_lat", req_cyc - hcyc, 2);
            check("b_after_req", bcyc - req_cyc, 1);
            check("wr_fields", {last_we, last_addr, last_be, last_wdata}, {1'b1, off[11:0], s, d});
        end else begin
            check("wr_oow_no_req", req_cnt - req0, 0);
        end
        k = $urandom_range(0, 3);
        repeat (k) begin
            @(negedge clk);
            check("b_stable", {bus.bvalid, bus.bresp}, {1'b1, expb});
        end
        bus.bready = 1'b1;
        @(posedge clk); #1;
        bus.bready = 1'b0;
        @(negedge clk);
        check("b_single", bus.bvalid, 0);
        if (inwin)
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[off[11:2]][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic axi_read(input logic [31:0] a, input int hold);
        int          n, t, r, req0;
        bit          inwin;
        logic [31:0] off, expd;
        logic [1:0]  expr;
        n = 0; t = -1; req0 = req_cnt;
        off = a - BASE; inwin = off < SIZE;
        expd = inwin ? ref_mem[off[11:2]] : 32'h0;
        expr = inwin ? 2'b00 : 2'b10;
        @(posedge clk); #1;
        bus.arvalid = 1'b1; bus.araddr = a;
        while (t < 0 && n < 40) begin
            @(negedge clk);
            if (bus.arready) t = cyc;
            @(posedge clk); #1;
            n++;
        end
        bus.arvalid = 1'b0;
        check("ar_accept", t >= 0, 1);
        n = 0;
        @(negedge clk);
        while (!bus.rvalid && n < 20) begin @(negedge clk); n++; end
        r = cyc;
        check("rvalid_seen", bus.rvalid, 1);
        check("rvalid_lat", r - t, inwin ? 2 + RL : 1);
        if (inwin) begin
            check("rd_req_cnt", req_cnt - req0, 1);
            check("rd_req_lat", req_cyc - t, 1);
            check("rd_fields", {last_we, last_addr, last_be}, {1'b0, off[11:0], 4'hF});
        end else begin
            check("rd_oow_no_req", req_cnt - req0, 0);
        end
        check("rdata", bus.rdata, expd);
        check("rresp", bus.rresp, expr);
        repeat (hold) begin
            @(negedge clk);
            check("r_stable", {bus.rvalid, bus.rresp, bus.rdata}, {1'b1, expr, expd});
        end
        bus.rready = 1'b1;
        @(posedge clk); #1;
        bus.rready = 1'b0;
        @(negedge clk);
        check("r_single", bus.rvalid, 0);
    endtask

    initial begin
        logic [31:0] a;
        bit          exp_r, hs_ar, hs_aw, hs_w, rd, bd;
        int          n;

        bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0;
        bus.bready = 0; bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_readies", {bus.awready, bus.wready, bus.arready}, 0);
        check("rst_valids", {bus.bvalid, bus.rvalid}, 0);
        check("rst_resp_data", {bus.bresp, bus.rresp, bus.rdata}, 0);
        check("rst_device", {dreq, dwe, daddr, dbe, dwdata}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);

        axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, 0);
        axi_read(32'h10, 0);
        axi_write(32'h20, 32'h1122_3344, 4'b0101, 2);
        axi_read(32'h20, 1);
        axi_write(32'h30, 32'hA5A5_0001, 4'hF, 1);
        axi_read(32'h30, 5);
        axi_write(32'h1000, 32'hCAFE_F00D, 4'hF, 0);
        axi_read(32'h2000, 2);
        axi_write(32'hFFC, 32'h0BAD_CAFE, 4'b1100, 0);
        axi_read(32'hFFE, 0);
        axi_read(32'hFFFF_FFFC, 0);

        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 9) == 0) ? 32'h1000 + $urandom_range(0, 32'hFFFF)
                                            : 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
            else
                axi_read(a, int'($urandom_range(0, 3)));
        end

        // Reset while the read waits on the device.
        @(posedge clk); #1;
        bus.arvalid = 1'b1; bus.araddr = 32'h10;
        @(negedge clk);
        check("mid_ar_ready", bus.arready, 1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        @(negedge clk);
        check("mid_req", {dreq, dwe}, 2'b10);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valids", {bus.rvalid, bus.bvalid, dreq}, 0);
        check("mid_rst_data", {bus.rdata, bus.rresp, bus.bresp}, 0);
        check("mid_rst_ready", bus.arready, 1);
        repeat (RL + 3) begin
            @(negedge clk);
            check("mid_no_rvalid", bus.rvalid, 0);
        end
        axi_read(32'h10, 1);

        // Simultaneous read and write requests; grants must alternate R, W, R, W.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.arvalid = 1'b1; bus.araddr = 32'h100;
            bus.awvalid = 1'b1; bus.awaddr = 32'h200 + 32'(4 * i);
            bus.wvalid = 1'b1; bus.wdata = 32'h5000_0000 + 32'(i); bus.wstrb = 4'hF;
            ref_mem[(32'h200 + 4 * i) >> 2] = 32'h5000_0000 + 32'(i);
            @(negedge clk);
            exp_r = (i % 2 == 0);
            check("arb_ar", bus.arready, exp_r);
            check("arb_aw_w", {bus.awready, bus.wready}, {!exp_r, !exp_r});
            bus.bready = 1'b1; bus.rready = 1'b1;
            rd = 0; bd = 0; n = 0;
            while (!(rd && bd) && n < 60) begin
                hs_ar = bus.arvalid && bus.arready;
                hs_aw = bus.awvalid && bus.awready;
                hs_w  = bus.wvalid && bus.wready;
                if (bus.rvalid) rd = 1;
                if (bus.bvalid) bd = 1;
                @(posedge clk); #1;
                if (hs_ar) bus.arvalid = 1'b0;
                if (hs_aw) bus.awvalid = 1'b0;
                if (hs_w)  bus.wvalid = 1'b0;
                n++;
                @(negedge clk);
            end
            bus.bready = 1'b0; bus.rready = 1'b0;
            bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
            check("arb_complete", rd && bd, 1);
        end
        axi_read(32'h204, 0);

        check("idle_outputs_zero", idle_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
